// File: rtl/game_timer_ctrl.sv
// Round timer for a whack-a-mole style game: counts down round seconds,
// emits a mole pulse per speed period and ramps the speed level over time.
module game_timer_ctrl #(
   parameter int CLK_HZ    = 50000000,
   parameter int ROUND_SEC = 30,
   parameter int RAMP_SEC  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   input  logic        pause,
   input  logic [1:0]  level,
   output logic [27:0] counter_max,
   output logic        mole_tick,
   output logic        sec_tick,
   output logic [5:0]  seconds_left,
   output logic [1:0]  cur_level,
   output logic [1:0]  state,
   output logic        round_done
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [27:0] HZ_M1     = 28'(CLK_HZ - 1);
   localparam logic [5:0]  ROUND_LEN = 6'(ROUND_SEC);
   localparam logic [5:0]  RAMP_LAST = 6'(RAMP_SEC - 1);

   // Mole period minus one for a speed level: each level halves the period.
   function automatic logic [27:0] period_m1(input logic [1:0] lvl);
      logic [27:0] hz;
      hz = 28'(CLK_HZ);
      case (lvl)
         2'd0:    return hz - 28'd1;
         2'd1:    return (hz >> 1) - 28'd1;
         2'd2:    return (hz >> 2) - 28'd1;
         2'd3:    return (hz >> 3) - 28'd1;
         default: return hz - 28'd1;
      endcase
   endfunction

   state_t      state_r,        state_s;
   logic [27:0] sec_cnt_r,      sec_cnt_s;
   logic [27:0] tick_cnt_r,     tick_cnt_s;
   logic [5:0]  ramp_cnt_r,     ramp_cnt_s;
   logic [5:0]  seconds_left_r, seconds_left_s;
   logic [1:0]  cur_level_r,    cur_level_s;
   logic        mole_tick_r,    mole_tick_s;
   logic        sec_tick_r,     sec_tick_s;
   logic        round_done_r,   round_done_s;
   logic        step_s;

   assign counter_max  = period_m1(cur_level_r);
   assign mole_tick    = mole_tick_r;
   assign sec_tick     = sec_tick_r;
   assign seconds_left = seconds_left_r;
   assign cur_level    = cur_level_r;
   assign state        = state_r;
   assign round_done   = round_done_r;

   // Next-state logic: command decode (stop > start > pause), then one counting step.
   always_comb begin
      state_s        = state_r;
      sec_cnt_s      = sec_cnt_r;
      tick_cnt_s     = tick_cnt_r;
      ramp_cnt_s     = ramp_cnt_r;
      seconds_left_s = seconds_left_r;
      cur_level_s    = cur_level_r;
      mole_tick_s    = 1'b0;
      sec_tick_s     = 1'b0;
      round_done_s   = 1'b0;
      step_s         = 1'b0;

      if (stop) begin
         state_s        = ST_IDLE;
         seconds_left_s = 6'd0;
         cur_level_s    = 2'd0;
      end else if (start && (state_r == ST_IDLE || state_r == ST_DONE)) begin
         state_s        = ST_RUN;
         cur_level_s    = level;
         seconds_left_s = ROUND_LEN;
         sec_cnt_s      = HZ_M1;
         tick_cnt_s     = period_m1(level);
         ramp_cnt_s     = 6'd0;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (pause) begin
                  state_s = ST_PAUSED;
               end else begin
                  step_s = 1'b1;
               end
            end
            // Resuming edge counts, so a round is delayed by exactly the cycles pause was high.
            ST_PAUSED: begin
               if (pause) begin
                  state_s = ST_PAUSED;
               end else begin
                  step_s = 1'b1;
               end
            end
            default: begin
               state_s = state_r;
            end
         endcase
      end

      if (step_s) begin
         state_s = ST_RUN;
         // Reload uses the level in effect now, so a ramp never cuts a period short.
         if (tick_cnt_r == 28'd0) begin
            mole_tick_s = 1'b1;
            tick_cnt_s  = counter_max;
         end else begin
            tick_cnt_s  = tick_cnt_r - 28'd1;
         end
         if (sec_cnt_r == 28'd0) begin
            sec_tick_s     = 1'b1;
            sec_cnt_s      = HZ_M1;
            seconds_left_s = seconds_left_r - 6'd1;
            if (ramp_cnt_r >= RAMP_LAST) begin
               ramp_cnt_s = 6'd0;
               if (cur_level_r != 2'd3) begin
                  cur_level_s = cur_level_r + 2'd1;
               end else begin
                  cur_level_s = cur_level_r;
               end
            end else begin
               ramp_cnt_s = ramp_cnt_r + 6'd1;
            end
            if (seconds_left_r <= 6'd1) begin
               state_s        = ST_DONE;
               round_done_s   = 1'b1;
               seconds_left_s = 6'd0;
            end else begin
               state_s        = ST_RUN;
            end
         end else begin
            sec_cnt_s = sec_cnt_r - 28'd1;
         end
      end else begin
         step_s = 1'b0;
      end
   end

   // State and output registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r        <= ST_IDLE;
         sec_cnt_r      <= 28'd0;
         tick_cnt_r     <= 28'd0;
         ramp_cnt_r     <= 6'd0;
         seconds_left_r <= 6'd0;
         cur_level_r    <= 2'd0;
         mole_tick_r    <= 1'b0;
         sec_tick_r     <= 1'b0;
         round_done_r   <= 1'b0;
      end else begin
         state_r        <= state_s;
         sec_cnt_r      <= sec_cnt_s;
         tick_cnt_r     <= tick_cnt_s;
         ramp_cnt_r     <= ramp_cnt_s;
         seconds_left_r <= seconds_left_s;
         cur_level_r    <= cur_level_s;
         mole_tick_r    <= mole_tick_s;
         sec_tick_r     <= sec_tick_s;
         round_done_r   <= round_done_s;
      end
   end

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Self-checking bench for game_timer_ctrl with CLK_HZ=8, ROUND_SEC=3, RAMP_SEC=2.
module tb_game_timer_ctrl;

   localparam int HZ    = 8;
   localparam int RS    = 3;
   localparam int RAMP  = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        pause = 1'b0;
   logic [1:0]  level = 2'd0;
   logic [27:0] counter_max;
   logic        mole_tick;
   logic        sec_tick;
   logic [5:0]  seconds_left;
   logic [1:0]  cur_level;
   logic [1:0]  state;
   logic        round_done;

   int errors = 0;
   int checks = 0;

   game_timer_ctrl #(.CLK_HZ(HZ), .ROUND_SEC(RS), .RAMP_SEC(RAMP)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
      .level(level), .counter_max(counter_max), .mole_tick(mole_tick),
      .sec_tick(sec_tick), .seconds_left(seconds_left), .cur_level(cur_level),
      .state(state), .round_done(round_done)
   );

   always #5 clk = ~clk;

   // Model: the round is described by elapsed counting edges since start.
   logic [1:0] m_state = 2'd0;
   logic [5:0] m_secs  = 6'd0;
   logic [1:0] m_cur   = 2'd0;
   logic       m_mole  = 1'b0;
   logic       m_sec   = 1'b0;
   logic       m_done  = 1'b0;
   int         m_e     = 0;
   int         m_next  = 0;
   int         m_lvl0  = 0;

   function automatic int period(input int l);
      return HZ / (1 << l);
   endfunction

   // Behavioural model update on every clock edge or reset.
   always @(posedge clk or negedge reset) begin : model_p
      int e, nx, cur, secs, st, l0;
      logic mo, se, dn;
      if (!reset) begin
         m_state <= 2'd0; m_secs <= 6'd0; m_cur <= 2'd0;
         m_mole <= 1'b0; m_sec <= 1'b0; m_done <= 1'b0;
         m_e <= 0; m_next <= 0; m_lvl0 <= 0;
      end else begin
         e = m_e; nx = m_next; cur = int'(m_cur); secs = int'(m_secs);
         st = int'(m_state); l0 = m_lvl0; mo = 1'b0; se = 1'b0; dn = 1'b0;
         if (stop) begin
            st = 0; secs = 0; cur = 0;
         end else if (start && (st == 0 || st == 3)) begin
            st = 1; l0 = int'(level); cur = l0; secs = RS; e = 0; nx = period(l0);
         end else if (st == 1 && pause) begin
            st = 2;
         end else if ((st == 1 || st == 2) && !pause) begin
            e = e + 1;
            if (e == nx) begin
               mo = 1'b1;
               nx = e + period(cur);
            end
            if (e % HZ == 0) begin
               se = 1'b1;
               secs = RS - e / HZ;
               cur = l0 + (e / HZ) / RAMP;
               if (cur > 3) cur = 3;
            end
            if (secs == 0) begin
               st = 3; dn = 1'b1;
            end else begin
               st = 1;
            end
         end
         m_e <= e; m_next <= nx; m_lvl0 <= l0;
         m_cur <= 2'(cur); m_secs <= 6'(secs); m_state <= 2'(st);
         m_mole <= mo; m_sec <= se; m_done <= dn;
      end
   end

   logic [40:0] dut_vec, exp_vec;
   assign dut_vec = {state, seconds_left, cur_level, counter_max, mole_tick, sec_tick, round_done};
   assign exp_vec = {m_state, m_secs, m_cur, 28'(HZ / (1 << m_cur) - 1), m_mole, m_sec, m_done};

   // Cycle-by-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      checks++;
      if (dut_vec !== exp_vec) begin
         errors++;
         $display("FAIL cycle t=%0t got st=%0d sl=%0d lv=%0d cm=%0d m/s/d=%b%b%b expected st=%0d sl=%0d lv=%0d cm=%0d m/s/d=%b%b%b",
                  $time, state, seconds_left, cur_level, counter_max, mole_tick, sec_tick, round_done,
                  m_state, m_secs, m_cur, HZ / (1 << m_cur) - 1, m_mole, m_sec, m_done);
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   int done_at, moles, secs, st12, m17, cur16;

   // Start a round with the given level and release start after the edge.
   task automatic begin_round(input logic [1:0] lvl);
      level = lvl; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Observe n edges counting pulses and the edge of round_done.
   task automatic observe(input int n);
      done_at = 0; moles = 0; secs = 0;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         if (round_done) done_at = k;
         moles += int'(mole_tick);
         secs  += int'(sec_tick);
         if (k == 17) m17 = int'(mole_tick);
         if (k == 16) cur16 = int'(cur_level);
      end
   endtask

   initial begin
      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_state", state, 0);
      chk("reset_secs", seconds_left, 0);
      chk("reset_cmax", counter_max, 7);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_hold", state, 0);

      // Basic round at level 0
      begin_round(2'd0);
      chk("start_secs", seconds_left, 3);
      chk("start_state", state, 1);
      observe(30);
      chk("basic_done_at", done_at, 24);
      chk("basic_moles", moles, 3);
      chk("basic_secticks", secs, 3);
      chk("basic_state", state, 3);
      chk("basic_level", cur_level, 1);
      chk("basic_secs_left", seconds_left, 0);

      // Ramp from level 2 to 3
      begin_round(2'd2);
      observe(30);
      chk("ramp_moles", moles, 15);
      chk("ramp_no_mole_17", m17, 0);
      chk("ramp_level_16", cur16, 3);
      chk("ramp_done_at", done_at, 24);

      // Saturation at level 3
      begin_round(2'd3);
      chk("sat_cmax", counter_max, 0);
      observe(30);
      chk("sat_moles", moles, 24);
      chk("sat_level", cur_level, 3);

      // Pause for 5 cycles mid-second
      begin_round(2'd0);
      done_at = 0; moles = 0; st12 = 0;
      for (int k = 1; k <= 35; k++) begin
         @(negedge clk);
         if (round_done) done_at = k;
         moles += int'(mole_tick);
         if (k == 12) st12 = int'(state);
         if (k == 10) pause = 1'b1;
         if (k == 15) pause = 1'b0;
      end
      chk("pause_state", st12, 2);
      chk("pause_done_at", done_at, 29);
      chk("pause_moles", moles, 3);

      // Priority: start+stop+pause together on a would-be tick edge
      begin_round(2'd1);
      repeat (7) @(negedge clk);
      start = 1'b1; stop = 1'b1; pause = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0; pause = 1'b0;
      chk("prio_state", state, 0);
      chk("prio_secs", seconds_left, 0);
      chk("prio_pulses", {mole_tick, sec_tick, round_done}, 0);

      // Start held in RUN has no effect
      level = 2'd0; start = 1'b1;
      done_at = 0;
      for (int k = 0; k <= 30; k++) begin
         @(negedge clk);
         if (round_done) done_at = k;
         if (k == 5) start = 1'b0;
      end
      chk("start_in_run_done_at", done_at, 24);

      // Asynchronous reset mid-round
      begin_round(2'd0);
      repeat (6) @(negedge clk);
      #3 reset = 1'b0;
      #1;
      chk("async_state", state, 0);
      chk("async_secs", seconds_left, 0);
      chk("async_pulses", {mole_tick, sec_tick, round_done}, 0);
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      repeat (5) @(negedge clk);
      chk("post_reset_idle", state, 0);
      begin_round(2'd0);
      observe(30);
      chk("post_reset_done_at", done_at, 24);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/game_timer_ctrl.md
GAME_TIMER_CTRL -- requirements
Module: game_timer_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, meaning clock cycles per second; it SHALL be a multiple of 8 and at least 8.
REQ-002 The block SHALL have parameter ROUND_SEC, default 30, meaning round length in seconds; range 1..63.
REQ-003 The block SHALL have parameter RAMP_SEC, default 10, meaning seconds between automatic speed-level increments; range 1..63.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: level-sampled request to begin a round.
REQ-007 The block SHALL have port stop, input, 1 bit: abort the round and return to idle.
REQ-008 The block SHALL have port pause, input, 1 bit: while high, freeze a running round.
REQ-009 The block SHALL have port level, input, 2 bits: initial speed level, latched on start.
REQ-010 The block SHALL have port counter_max, output, 28 bits: current mole-tick reload value, for configuring downstream dividers.
REQ-011 The block SHALL have port mole_tick, output, 1 bit: one-cycle pulse per mole period.
REQ-012 The block SHALL have port sec_tick, output, 1 bit: one-cycle pulse per elapsed second.
REQ-013 The block SHALL have port seconds_left, output, 6 bits: remaining round seconds.
REQ-014 The block SHALL have port cur_level, output, 2 bits: effective speed level.
REQ-015 The block SHALL have port state, output, 2 bits: IDLE=0, RUN=1, PAUSED=2, DONE=3.
REQ-016 The block SHALL have port round_done, output, 1 bit: one-cycle pulse on entry to DONE.

Function
REQ-017 counter_max SHALL be derived from cur_level, combinationally from registered state:
- level 0: CLK_HZ-1
- level 1: CLK_HZ/2-1
- level 2: CLK_HZ/4-1
- level 3: CLK_HZ/8-1
REQ-018 The block SHALL contain a 28-bit seconds down-counter (sec_cnt) and a 28-bit mole down-counter (tick_cnt); both SHALL change only in RUN or on a start transition.
REQ-019 Command priority SHALL be stop > start > pause when inputs coincide.
REQ-020 stop high in any state SHALL, on the next edge, enter IDLE, clear seconds_left and cur_level to 0, and suppress all pulses that cycle.
REQ-021 start high in IDLE or DONE SHALL, on the next edge:
- enter RUN;
- set cur_level=level and seconds_left=ROUND_SEC;
- load sec_cnt=CLK_HZ-1 and tick_cnt=the period for the latched level;
- clear the ramp second count.
REQ-022 start SHALL be ignored in RUN and PAUSED.
REQ-023 In RUN with pause high, the block SHALL enter PAUSED on the next edge; that edge SHALL not decrement counters or emit pulses.
REQ-024 PAUSED SHALL return to RUN on the first edge with pause low; all counters and seconds_left SHALL hold while in PAUSED.
REQ-025 Each RUN cycle, tick_cnt SHALL decrement by 1. On reaching 0, mole_tick SHALL pulse that cycle and tick_cnt SHALL reload with the counter_max value in effect on that cycle.
REQ-026 Each RUN cycle, sec_cnt SHALL decrement by 1. On reaching 0:
- sec_tick SHALL pulse that cycle;
- sec_cnt SHALL reload to CLK_HZ-1;
- seconds_left SHALL decrement by 1.
REQ-027 When sec_cnt==0 and seconds_left==1, the next edge SHALL:
- set seconds_left=0;
- enter DONE;
- assert round_done for exactly one cycle.
REQ-028 When sec_cnt==0 in that final cycle, sec_tick SHALL also pulse that cycle, and mole_tick SHALL pulse if tick_cnt==0.
REQ-029 The block SHALL count sec_tick pulses in RUN; every RAMP_SEC-th pulse, cur_level SHALL increment, saturating at 3, and the ramp count SHALL reset.
REQ-030 A level change SHALL take effect at the next tick_cnt reload, never truncating a period in progress.
REQ-031 DONE SHALL hold seconds_left=0 and cur_level, emit no pulses, and wait for start or stop.
REQ-032 All outputs except counter_max SHALL be registered; pulses SHALL be exactly one clk wide.

Reset
REQ-033 While reset is low, the block SHALL immediately, asynchronously, force:
- state=IDLE;
- seconds_left=0, cur_level=0;
- sec_cnt=0, tick_cnt=0, ramp count=0;
- mole_tick=0, sec_tick=0, round_done=0.
REQ-034 Reset asserted mid-round SHALL abandon the round; after release, the block SHALL remain in IDLE until start.

Verification (CLK_HZ=8, ROUND_SEC=3, RAMP_SEC=2)
REQ-035 Basic round: start with level=0 -> RUN.
- mole_tick and sec_tick pulse every 8 cycles;
- seconds_left steps 3,2,1,0;
- round_done pulses once, 24 cycles after start;
- state=DONE.
REQ-036 Ramp: start with level=2 -> mole_tick every 2 cycles; after the 2nd sec_tick, cur_level=3 and mole_tick every cycle from the next reload.
REQ-037 Saturation: start with level=3 -> cur_level stays 3 through the ramp; mole_tick every cycle.
REQ-038 Pause: pause high 5 cycles mid-second -> state=PAUSED, counters frozen, no pulses; after release, the round ends exactly 5 cycles later than the unpaused case.
REQ-039 Priority: start, stop and pause high together in RUN -> IDLE, seconds_left=0, no pulses; start alone while in RUN -> no effect on counters.
REQ-040 Async reset mid-RUN (not clock-aligned) -> outputs cleared immediately; after release, stays in IDLE until start.
